// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
//   Drains a PS/2 receiver FIFO one byte at a time (IDLE -> POP -> GAP),
//   decodes set-2 E0/F0 prefixes into make/break events, suppresses or
//   counts typematic repeats, tracks the held key, and keeps a two-digit
//   BCD press counter plus a sticky FIFO-overflow flag.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   ready        receiver FIFO non-empty
//   data[7:0]    receiver FIFO head byte, valid while ready=1
//   overflow     receiver FIFO overflow indication
//   clr          synchronous clear of press_cnt and ovf_sticky
//   nextdata_n   active-low FIFO pop strobe (one cycle, in POP)
//   key_code     scan code of last accepted make
//   key_ext      last accepted make carried an E0 prefix
//   key_down     {key_ext,key_code} is currently held
//   key_valid    one-cycle pulse per accepted new press
//   key_release  one-cycle pulse when the held key is released
//   press_cnt    BCD press count, [7:4] tens, [3:0] units
//   ovf_sticky   set by any overflow cycle, cleared by clr
// ---------------------------------------------------------------------------
module ps2_key_ctrl #(
  parameter int REPEAT_COUNT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  input  logic       clr,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_down,
  output logic       key_valid,
  output logic       key_release,
  output logic [7:0] press_cnt,
  output logic       ovf_sticky
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_ERR0 = 8'h00;
  localparam logic [7:0] CODE_ERR1 = 8'hFF;

  state_t     r_state;
  logic [7:0] r_byte;
  logic       r_ext_pend;
  logic       r_brk_pend;
  logic       r_nextdata_n;
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic       r_key_down;
  logic       r_key_valid;
  logic       r_key_release;
  logic [7:0] r_press_cnt;
  logic       r_ovf_sticky;

  logic       w_plain;
  logic       w_match;
  logic       w_press;
  logic       w_release;
  logic [7:0] w_cnt_inc;

  // Decode of the latched byte; only acted on while in POP.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_cnt_inc = r_press_cnt;
    w_plain   = !(r_byte inside {CODE_EXT, CODE_BRK, CODE_ERR0, CODE_ERR1});
    // A "match" compares the incoming (prefix, code) pair with the held key.
    w_match   = r_key_down && ({r_ext_pend, r_byte} == {r_key_ext, r_key_code});
    // A repeat of the held key counts as a press only when REPEAT_COUNT is set.
    w_press   = (r_state == POP) && w_plain && !r_brk_pend &&
                (!w_match || (REPEAT_COUNT != 0));
    w_release = (r_state == POP) && w_plain && r_brk_pend && w_match;

    // BCD increment: units 9 carries into tens, 99 wraps to 00.
    if (r_press_cnt[3:0] == 4'd9) begin
      w_cnt_inc[3:0] = 4'd0;
      w_cnt_inc[7:4] = (r_press_cnt[7:4] == 4'd9) ? 4'd0 : r_press_cnt[7:4] + 4'd1;
    end else begin
      w_cnt_inc[3:0] = r_press_cnt[3:0] + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_byte        <= 8'h00;
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_nextdata_n  <= 1'b1;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_down    <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_press_cnt   <= 8'h00;
      r_ovf_sticky  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      r_key_valid   <= w_press;
      r_key_release <= w_release;

      case (r_state)
        IDLE: begin
          if (ready) begin
            r_byte       <= data;
            r_nextdata_n <= 1'b0;  // low for the whole POP cycle
            r_state      <= POP;
          end
        end
        POP: begin
          r_nextdata_n <= 1'b1;
          r_state      <= GAP;
          if (r_byte == CODE_EXT) begin
            r_ext_pend <= 1'b1;
          end else if (r_byte == CODE_BRK) begin
            r_brk_pend <= 1'b1;
          end else begin
            // Data bytes and error codes both terminate a prefix sequence.
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
          if (w_press) begin
            r_key_code <= r_byte;
            r_key_ext  <= r_ext_pend;
            r_key_down <= 1'b1;
          end
          if (w_release) begin
            r_key_down <= 1'b0;
          end
        end
        GAP: begin
          // One idle cycle so the FIFO head settles before ready is re-sampled.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // clr has priority over a same-cycle increment or overflow set.
      if (clr) begin
        r_press_cnt  <= 8'h00;
        r_ovf_sticky <= 1'b0;
      end else begin
        if (w_press) r_press_cnt <= w_cnt_inc;
        if (overflow) r_ovf_sticky <= 1'b1;
      end
    end
  end

  assign nextdata_n  = r_nextdata_n;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_down    = r_key_down;
  assign key_valid   = r_key_valid;
  assign key_release = r_key_release;
  assign press_cnt   = r_press_cnt;
  assign ovf_sticky  = r_ovf_sticky;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_ctrl
//   Two instances share one modelled receiver FIFO: u0 with REPEAT_COUNT=0,
//   u1 with REPEAT_COUNT=1. A behavioural key model (held key, pending
//   prefixes, integer press counts) predicts outputs every cycle.
// ---------------------------------------------------------------------------
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;
  logic       clr = 1'b0;

  logic       nd0, nd1;
  logic [7:0] code0, code1, cnt0, cnt1;
  logic       ext0, ext1, down0, down1, val0, val1, rel0, rel1, ovf0, ovf1;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.REPEAT_COUNT(0)) u0 (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow), .clr(clr),
    .nextdata_n(nd0), .key_code(code0), .key_ext(ext0), .key_down(down0),
    .key_valid(val0), .key_release(rel0), .press_cnt(cnt0), .ovf_sticky(ovf0)
  );

  ps2_key_ctrl #(.REPEAT_COUNT(1)) u1 (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow), .clr(clr),
    .nextdata_n(nd1), .key_code(code1), .key_ext(ext1), .key_down(down1),
    .key_valid(val1), .key_release(rel1), .press_cnt(cnt1), .ovf_sticky(ovf1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receiver FIFO model
  logic [7:0] fifo[$];

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    ready = 1'b1;
    data  = fifo[0];
  endtask

  // Behavioural key model
  bit         m_ext, m_brk, m_down, m_ovf;
  logic [8:0] m_key;
  int         m_cnt0, m_cnt1;
  bit         e_val0, e_val1, e_rel;
  bit         prev_nd;
  int         cyc;
  int         low_times[$];
  int         seen_v0, seen_v1, seen_rel;
  logic [7:0] mon_b;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, u;
    t = 4'((n / 10) % 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (m_brk) begin
        if (m_down && {m_ext, b} == m_key) begin
          m_down = 1'b0;
          e_rel  = 1'b1;
        end
      end else if (m_down && {m_ext, b} == m_key) begin
        m_cnt1 = (m_cnt1 + 1) % 100;  // repeat counts only when repeats are presses
        e_val1 = 1'b1;
      end else begin
        m_down = 1'b1;
        m_key  = {m_ext, b};
        m_cnt0 = (m_cnt0 + 1) % 100;
        m_cnt1 = (m_cnt1 + 1) % 100;
        e_val0 = 1'b1;
        e_val1 = 1'b1;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Cycle monitor: compare, then advance the model for the coming edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("key_code",  code0,  m_key[7:0]);
      check("key_ext",   ext0,   m_key[8]);
      check("key_down",  down0,  m_down);
      check("key_valid", val0,   e_val0);
      check("key_rel",   rel0,   e_rel);
      check("press_cnt", cnt0,   bcd(m_cnt0));
      check("ovf",       ovf0,   m_ovf);
      check("rc1_valid", val1,   e_val1);
      check("rc1_cnt",   cnt1,   bcd(m_cnt1));
      check("rc1_code",  {ext1, code1, down1}, {m_key, m_down});
      check("nd_pair",   (!prev_nd && !nd0), 1'b0);
      if (val0) seen_v0++;
      if (val1) seen_v1++;
      if (rel0) seen_rel++;
      e_val0 = 1'b0;
      e_val1 = 1'b0;
      e_rel  = 1'b0;
      if (!nd0) begin
        low_times.push_back(cyc);
        check("pop_nonempty", fifo.size() != 0, 1'b1);
        if (fifo.size() != 0) begin
          mon_b = fifo.pop_front();
          model_byte(mon_b);
        end
      end
      if (overflow) m_ovf = 1'b1;
      if (clr) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_ovf  = 1'b0;
      end
      ready = (fifo.size() != 0);
      data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
      prev_nd = nd0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_down = 0; m_ovf = 0; m_key = '0;
    m_cnt0 = 0; m_cnt1 = 0; e_val0 = 0; e_val1 = 0; e_rel = 0;
    prev_nd = 1; seen_v0 = 0; seen_v1 = 0; seen_rel = 0;
  endtask

  // Asserts reset immediately (called away from clock edges) and checks reset values.
  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    overflow = 1'b0;
    fifo.delete();
    ready = 1'b0;
    data  = 8'h00;
    model_reset();
    #1;
    check("rst_nd",    nd0,   1'b1);
    check("rst_code",  code0, 8'h00);
    check("rst_ext",   ext0,  1'b0);
    check("rst_down",  down0, 1'b0);
    check("rst_valid", val0,  1'b0);
    check("rst_rel",   rel0,  1'b0);
    check("rst_cnt",   cnt0,  8'h00);
    check("rst_ovf",   ovf0,  1'b0);
    check("rst_cnt1",  cnt1,  8'h00);
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain();
    int k = 0;
    while (fifo.size() != 0 && k < 2000) begin
      tick();
      k++;
    end
    check("drain_timeout", fifo.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_pop();
    int k = 0;
    while (nd0 !== 1'b0 && k < 50) begin
      tick();
      k++;
    end
    check("pop_wait", nd0, 1'b0);
  endtask

  logic [7:0] codes[4] = '{8'h1C, 8'h32, 8'h75, 8'h23};

  initial begin
    logic [7:0] last_code;
    #2;
    do_reset();

    // Press / release
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("pr_cnt",   cnt0,     8'h01);
    check("pr_code",  code0,    8'h1C);
    check("pr_down",  down0,    1'b0);
    check("pr_nval",  seen_v0,  1);
    check("pr_nrel",  seen_rel, 1);

    // Typematic repeats
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("tm_cnt0",  cnt0,    8'h01);
    check("tm_cnt1",  cnt1,    8'h03);
    check("tm_nval0", seen_v0, 1);
    check("tm_nval1", seen_v1, 3);

    // Extended key and foreign break
    do_reset();
    push(8'hE0); push(8'h75);
    drain();
    check("ex_ext",   ext0,  1'b1);
    check("ex_code",  code0, 8'h75);
    push(8'hF0); push(8'h75);
    drain();
    check("ex_fbrk_down", down0,    1'b1);
    check("ex_fbrk_rel",  seen_rel, 0);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("ex_down", down0,    1'b0);
    check("ex_nrel", seen_rel, 1);

    // BCD wrap over 100 alternating presses
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      push((k % 2) ? 8'h1C : 8'h32);
      drain();
      check($sformatf("bcd_%0d", k), cnt0, bcd(k % 100));
    end

    // Overflow sticky, then clr on the same edge as a new-press decode
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    repeat (5) tick();
    check("ovf_held", ovf0, 1'b1);
    push(8'h1C);
    wait_pop();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    check("clr_cnt",  cnt0,  8'h00);
    check("clr_ovf",  ovf0,  1'b0);
    check("clr_code", code0, 8'h1C);

    // Handshake spacing with six preloaded bytes
    do_reset();
    low_times.delete();
    push(8'h1C); push(8'hF0); push(8'h1C); push(8'hE0); push(8'h75); push(8'h32);
    drain();
    check("hs_npulse", low_times.size(), 6);
    for (int i = 1; i < 6 && i < low_times.size(); i++)
      check($sformatf("hs_gap%0d", i), low_times[i] - low_times[i-1], 3);

    // Reset while F0 is in POP
    push(8'h1C);
    drain();
    push(8'hF0);
    wait_pop();
    do_reset();
    push(8'h1C);
    drain();
    check("rp_nval", seen_v0, 1);
    check("rp_cnt",  cnt0,    8'h01);
    check("rp_down", down0,   1'b1);

    // Randomized traffic against the model
    do_reset();
    last_code = 8'h1C;
    for (int it = 0; it < 600; it++) begin
      int sel;
      sel = $urandom_range(0, 11);
      if (sel <= 3) begin
        last_code = codes[sel];
        push(last_code);
      end else if (sel == 4) push(8'hE0);
      else if (sel <= 6) push(8'hF0);
      else if (sel == 7) push(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      else if (sel <= 9) push(last_code);
      if ($urandom_range(0, 15) == 0) overflow = 1'b1;
      if ($urandom_range(0, 23) == 0) clr = 1'b1;
      tick();
      overflow = 1'b0;
      clr = 1'b0;
      repeat ($urandom_range(0, 4)) tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
